// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache with a block refill over a request/busy handshake.
// Define ICACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT statistics ports.
module instruction_cache #(
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4,
  localparam int OFFSET_W      = $clog2(WORDS_PER_LINE) + 2
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           READ,
  input  logic [ADDR_WIDTH-1:0]          PC,
  output logic [31:0]                    INSTRUCTION,
  output logic                           BUSYWAIT,
  output logic                           MEM_READ,
  output logic [ADDR_WIDTH-OFFSET_W-1:0] MEM_ADDRESS,
  input  logic [32*WORDS_PER_LINE-1:0]   MEM_READDATA,
  input  logic                           MEM_BUSYWAIT
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]                    HIT_COUNT,
  output logic [31:0]                    MISS_COUNT
`endif
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int BLOCK_W = ADDR_WIDTH - OFFSET_W;
  localparam int TAG_W   = BLOCK_W - INDEX_W;
  localparam int WORD_W  = OFFSET_W - 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, MEM_RD, UPDATE} state_t;

  state_t state, next_state;

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_store  [NUM_LINES];
  logic [31:0]          data_store [NUM_LINES][WORDS_PER_LINE];
  logic [BLOCK_W-1:0]   miss_addr;

  logic [WORD_W-1:0]  offset;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [INDEX_W-1:0] miss_index;
  logic [TAG_W-1:0]   miss_tag;
  logic               hit;
  logic               start_miss;
  logic               refill_done;
  logic               unused_pc_bits;

  // PC[1:0] is ignored: fetches are always word aligned.
  assign unused_pc_bits = ^PC[1:0];

  assign offset     = PC[OFFSET_W-1:2];
  assign index      = PC[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign tag        = PC[ADDR_WIDTH-1:OFFSET_W+INDEX_W];
  assign miss_index = miss_addr[INDEX_W-1:0];
  assign miss_tag   = miss_addr[BLOCK_W-1:INDEX_W];

  assign hit         = READ & valid[index] & (tag_store[index] == tag);
  assign start_miss  = (state == IDLE) & READ & ~hit;
  assign refill_done = (state == MEM_RD) & ~MEM_BUSYWAIT;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start_miss)    next_state = MEM_RD;
      MEM_RD:  if (!MEM_BUSYWAIT) next_state = UPDATE;
      UPDATE:                     next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
  end

  always_comb begin
    INSTRUCTION = hit ? data_store[index][offset] : NOP;
    BUSYWAIT    = (state == IDLE) ? (READ & ~hit) : 1'b1;
    MEM_READ    = (state == MEM_RD);
    MEM_ADDRESS = (state == MEM_RD) ? miss_addr : '0;
  end

  // Clearing the valid bits is what invalidates the cache; a half-fetched block is never marked valid.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid     <= '0;
      miss_addr <= '0;
    end else begin
      if (start_miss)  miss_addr         <= PC[ADDR_WIDTH-1:OFFSET_W];
      if (refill_done) valid[miss_index] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; valid bits alone guard their contents.
  always_ff @(posedge CLK) begin
    if (refill_done) begin
      tag_store[miss_index] <= miss_tag;
      for (int w = 0; w < WORDS_PER_LINE; w++)
        data_store[miss_index][w] <= MEM_READDATA[32*w +: 32];
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
    end else begin
      if ((state == IDLE) && hit && (HIT_COUNT != 32'hFFFF_FFFF))
        HIT_COUNT <= HIT_COUNT + 32'd1;
      if (start_miss && (MISS_COUNT != 32'hFFFF_FFFF))
        MISS_COUNT <= MISS_COUNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Randomised self-checking bench for instruction_cache against a line-level reference model.
// Backing memory returns a block after a programmable number of busy cycles.
module tb_instruction_cache;

  localparam int AW  = 32;
  localparam int NL  = 8;
  localparam int WPL = 4;
  localparam int OW  = 4;
  localparam int BW  = AW - OW;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              READ;
  logic [AW-1:0]     PC;
  logic [31:0]       INSTRUCTION;
  logic              BUSYWAIT;
  logic              MEM_READ;
  logic [BW-1:0]     MEM_ADDRESS;
  logic [32*WPL-1:0] MEM_READDATA;
  logic              MEM_BUSYWAIT;
`ifdef ICACHE_STATS_EN
  logic [31:0]       HIT_COUNT;
  logic [31:0]       MISS_COUNT;
`endif

  instruction_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ         (READ),
    .PC           (PC),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_STATS_EN
    ,
    .HIT_COUNT    (HIT_COUNT),
    .MISS_COUNT   (MISS_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input int unsigned word_addr);
    return (word_addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Backing memory: busy for mem_lat cycles of each request, then data valid; garbage while busy.
  int mem_lat  = 5;
  int busy_cnt = 0;

  always @(posedge CLK) begin
    if (!MEM_READ)             busy_cnt <= 0;
    else if (busy_cnt < mem_lat) busy_cnt <= busy_cnt + 1;
  end

  assign MEM_BUSYWAIT = MEM_READ && (busy_cnt < mem_lat);

  always_comb begin
    MEM_READDATA = '0;
    for (int w = 0; w < WPL; w++) begin
      MEM_READDATA[32*w +: 32] = MEM_BUSYWAIT ? ~mem_word(int'(MEM_ADDRESS) * WPL + w)
                                              :  mem_word(int'(MEM_ADDRESS) * WPL + w);
    end
  end

  // Reference model: which block (tag) each line holds, plus expected statistics.
  bit          m_valid [NL];
  int unsigned m_tag   [NL];
  int unsigned m_hits;
  int unsigned m_misses;

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
    check({tag, "_hit_count"},  HIT_COUNT,  m_hits);
    check({tag, "_miss_count"}, MISS_COUNT, m_misses);
`else
    if (tag.len() == 0) $display("empty stats tag");
`endif
  endtask

  // One fetch, timed cycle by cycle from the model's hit/miss decision; starts and ends just after a rising edge.
  task automatic fetch(input logic [31:0] pc);
    int unsigned idx = (pc / 16) % NL;
    int unsigned tg  = pc / (16 * NL);
    logic [31:0] exp = mem_word(pc / 4);
    READ = 1'b1;
    PC   = pc;
    @(negedge CLK);
    if (m_valid[idx] && m_tag[idx] == tg) begin
      check("hit_instr", INSTRUCTION, exp);
      check("hit_busywait", BUSYWAIT, 1'b0);
      check("hit_mem_read", MEM_READ, 1'b0);
      m_hits++;
    end else begin
      check("miss_busywait", BUSYWAIT, 1'b1);
      check("miss_idle_mem_read", MEM_READ, 1'b0);
      m_misses++;
      for (int k = 0; k <= mem_lat; k++) begin
        @(negedge CLK);
        check("rd_mem_read", MEM_READ, 1'b1);
        check("rd_mem_address", MEM_ADDRESS, pc / 16);
        check("rd_busywait", BUSYWAIT, 1'b1);
      end
      @(negedge CLK);
      check("upd_mem_read", MEM_READ, 1'b0);
      check("upd_mem_address", MEM_ADDRESS, 32'h0);
      check("upd_busywait", BUSYWAIT, 1'b1);
      @(negedge CLK);
      check("fill_instr", INSTRUCTION, exp);
      check("fill_busywait", BUSYWAIT, 1'b0);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_hits++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycle(input logic [31:0] pc);
    READ = 1'b0;
    PC   = pc;
    @(negedge CLK);
    check("idle_busywait", BUSYWAIT, 1'b0);
    check("idle_instr", INSTRUCTION, NOP);
    check("idle_mem_read", MEM_READ, 1'b0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    READ  = 1'b0;
    PC    = '0;
    model_reset();

    #2;
    check("rst_instr", INSTRUCTION, NOP);
    check("rst_busywait_idle", BUSYWAIT, 1'b0);
    check("rst_mem_read", MEM_READ, 1'b0);
    check("rst_mem_address", MEM_ADDRESS, 32'h0);
    READ = 1'b1;
    #1;
    check("rst_busywait_read", BUSYWAIT, 1'b1);
    check_stats("rst");
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Cold miss on block 0, then the remaining words of that block hit.
    mem_lat = 5;
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    fetch(32'hC);
    check_stats("warm");

    // Conflict eviction on index 0, then an independent miss on index 1.
    fetch(32'h80);
    fetch(32'h0);
    fetch(32'h10);
    fetch(32'h0);
    fetch(32'h14);

    for (int i = 0; i < 8; i++) idle_cycle($urandom);
    fetch(32'h8);

    // Reset in the middle of a refill.
    READ = 1'b1;
    PC   = 32'h80;
    @(negedge CLK);
    check("mid_miss_busywait", BUSYWAIT, 1'b1);
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    check("mid_mem_read", MEM_READ, 1'b1);
    RESET = 1'b1;
    #1;
    check("mid_rst_mem_read", MEM_READ, 1'b0);
    check("mid_rst_mem_address", MEM_ADDRESS, 32'h0);
    check("mid_rst_busywait", BUSYWAIT, 1'b1);
    model_reset();
    check_stats("mid_rst");
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    fetch(32'h0);
    fetch(32'h80);
    fetch(32'h84);

    // Random fetch stream over 1 KiB so lines conflict often.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        idle_cycle($urandom);
      end else begin
        mem_lat = $urandom_range(0, 4);
        fetch($urandom_range(0, 255) * 4 + $urandom_range(0, 3));
      end
    end
    check_stats("final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
